// File: rtl/anita4_trigger_scaler_bank.sv
// Per-channel trigger flag scalers with gated, simultaneous snapshots and a registered read port.
// Define ANITA4_SCALER_OVERFLOW_FLAG_EN to add a sticky per-channel overflow bit as rd_data_o MSB.
module anita4_trigger_scaler_bank #(
    parameter int NUM_CH      = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int GATE_CYCLES = 1000000,
    parameter int ADDR_WIDTH  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_CH-1:0]     flag_i,
    input  logic                  enable_i,
    input  logic                  latch_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                  rd_en_i,
`ifdef ANITA4_SCALER_OVERFLOW_FLAG_EN
    output logic [CNT_WIDTH:0]    rd_data_o,
`else
    output logic [CNT_WIDTH-1:0]  rd_data_o,
`endif
    output logic                  rd_valid_o,
    output logic                  gate_done_o,
    output logic [15:0]           gate_count_o
);

    localparam int TW = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] C_MAX = '1;

    typedef enum logic {COUNT, LATCH} state_t;

    state_t               state;
    logic [TW-1:0]        timer;
    logic [CNT_WIDTH-1:0] cnt      [NUM_CH];
    logic [CNT_WIDTH-1:0] hold     [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_next [NUM_CH];
    logic [NUM_CH-1:0]    inc;
    logic [NUM_CH-1:0]    at_max;
    logic                 terminal;
    logic [CNT_WIDTH-1:0] rd_sel;

`ifdef ANITA4_SCALER_OVERFLOW_FLAG_EN
    logic [NUM_CH-1:0]    lost;
    logic [NUM_CH-1:0]    ovf_run;
    logic [NUM_CH-1:0]    ovf_hold;
    logic                 rd_ovf;
`endif

    // A pulse arriving on a saturated counter is dropped rather than wrapping.
    always_comb begin
        inc      = flag_i & {NUM_CH{enable_i}};
        terminal = (state == COUNT) && ((timer == T_LAST) || latch_req_i);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            at_max[ch]   = (cnt[ch] == C_MAX);
            cnt_next[ch] = cnt[ch] + {{(CNT_WIDTH-1){1'b0}}, inc[ch] & ~at_max[ch]};
        end
    end

    // Unmapped addresses fall through to zero.
    always_comb begin
        rd_sel = '0;
`ifdef ANITA4_SCALER_OVERFLOW_FLAG_EN
        rd_ovf = 1'b0;
`endif
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (rd_addr_i == ADDR_WIDTH'(ch)) begin
                rd_sel = hold[ch];
`ifdef ANITA4_SCALER_OVERFLOW_FLAG_EN
                rd_ovf = ovf_hold[ch];
`endif
            end
        end
    end

`ifdef ANITA4_SCALER_OVERFLOW_FLAG_EN
    assign lost = inc & at_max;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= COUNT;
            timer        <= '0;
            gate_done_o  <= 1'b0;
            gate_count_o <= '0;
            rd_valid_o   <= 1'b0;
            rd_data_o    <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt[ch]  <= '0;
                hold[ch] <= '0;
            end
`ifdef ANITA4_SCALER_OVERFLOW_FLAG_EN
            ovf_run  <= '0;
            ovf_hold <= '0;
`endif
        end else begin
            unique case (state)
                COUNT:   if (terminal) state <= LATCH;
                LATCH:   state <= COUNT;
                default: state <= COUNT;
            endcase
            gate_done_o <= terminal;
            rd_valid_o  <= rd_en_i;
            if (rd_en_i) begin
`ifdef ANITA4_SCALER_OVERFLOW_FLAG_EN
                rd_data_o <= {rd_ovf, rd_sel};
`else
                rd_data_o <= rd_sel;
`endif
            end
            // The terminal-cycle flag belongs to the gate that is ending.
            if (terminal) begin
                timer        <= '0;
                gate_count_o <= gate_count_o + 16'd1;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    hold[ch] <= cnt_next[ch];
                    cnt[ch]  <= '0;
                end
`ifdef ANITA4_SCALER_OVERFLOW_FLAG_EN
                ovf_hold <= ovf_run | lost;
                ovf_run  <= '0;
`endif
            end else begin
                timer <= timer + TW'(1);
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    cnt[ch] <= cnt_next[ch];
                end
`ifdef ANITA4_SCALER_OVERFLOW_FLAG_EN
                ovf_run <= ovf_run | lost;
`endif
            end
        end
    end

endmodule

// File: tb/tb_anita4_trigger_scaler_bank.sv
// Bench for anita4_trigger_scaler_bank: directed tables, corner sequences and a
// randomized run compared against a per-gate arithmetic reference model.
module tb_anita4_trigger_scaler_bank;

    localparam int GC   = 10;
    localparam int CW   = 16;
    localparam int MAXV = (1 << CW) - 1;
`ifdef ANITA4_SCALER_OVERFLOW_FLAG_EN
    localparam int DW    = CW + 1;
    localparam int DWB   = 5;
    localparam int B_SAT = 31;
`else
    localparam int DW    = CW;
    localparam int DWB   = 4;
    localparam int B_SAT = 15;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 16-bit counters, 10-cycle gate, 4-bit address to reach unmapped slots
    logic          rst, en, lreq, rden;
    logic [7:0]    flag;
    logic [3:0]    addr;
    logic [DW-1:0] rdd;
    logic          rdv, done;
    logic [15:0]   gcnt;

    anita4_trigger_scaler_bank #(
        .NUM_CH(8), .CNT_WIDTH(CW), .GATE_CYCLES(GC), .ADDR_WIDTH(4)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .flag_i(flag), .enable_i(en),
        .latch_req_i(lreq), .rd_addr_i(addr), .rd_en_i(rden),
        .rd_data_o(rdd), .rd_valid_o(rdv), .gate_done_o(done),
        .gate_count_o(gcnt)
    );

    // DUT B: 4-bit counters, 32-cycle gate, for saturation
    logic           b_rst, b_en, b_lreq, b_rden;
    logic [7:0]     b_flag;
    logic [2:0]     b_addr;
    logic [DWB-1:0] b_rdd;
    logic           b_rdv, b_done;
    logic [15:0]    b_gcnt;

    anita4_trigger_scaler_bank #(
        .NUM_CH(8), .CNT_WIDTH(4), .GATE_CYCLES(32), .ADDR_WIDTH(3)
    ) dut_b (
        .clk_i(clk), .rst_i(b_rst), .flag_i(b_flag), .enable_i(b_en),
        .latch_req_i(b_lreq), .rd_addr_i(b_addr), .rd_en_i(b_rden),
        .rd_data_o(b_rdd), .rd_valid_o(b_rdv), .gate_done_o(b_done),
        .gate_count_o(b_gcnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference model: gate position, per-channel tallies, last snapshot
    int m_cnt [8];
    int m_hold[8];
    int m_pos, m_gc, m_rdd;
    bit m_lat, m_done, m_rdv;

    task automatic model_edge();
        bit term;
        int v;
        if (rst) begin
            foreach (m_cnt[c]) begin m_cnt[c] = 0; m_hold[c] = 0; end
            m_pos = 0; m_gc = 0; m_rdd = 0;
            m_lat = 0; m_done = 0; m_rdv = 0;
            return;
        end
        term = !m_lat && (m_pos == GC - 1 || lreq);
        if (rden) m_rdd = (addr < 8) ? m_hold[addr] : 0;
        m_rdv = rden;
        for (int c = 0; c < 8; c++) begin
            v = m_cnt[c] + ((flag[c] && en) ? 1 : 0);
            if (v > MAXV) v = MAXV;
            if (term) begin m_hold[c] = v; m_cnt[c] = 0; end
            else m_cnt[c] = v;
        end
        m_pos  = term ? 0 : m_pos + 1;
        m_lat  = term;
        m_done = term;
        if (term) m_gc = (m_gc + 1) % 65536;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("done", done, m_done);
        chk("gate_count", gcnt, m_gc);
        chk("rd_valid", rdv, m_rdv);
        chk("rd_data", rdd, m_rdd);
    endtask

    task automatic step_b();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst = 1; flag = 0; en = 1; lreq = 0; rden = 0; addr = 0;
        step();
        rst = 0;
    endtask

    typedef struct {
        logic [7:0] flag;
        logic       en;
        logic       lreq;
        logic       exp_done;
    } vec_t;

    typedef struct {
        logic [3:0] addr;
        int         exp;
    } rd_t;

    vec_t s1[11];
    rd_t  rt[9];

    initial begin
        for (int i = 0; i < 11; i++) begin
            s1[i].flag     = (i == 1 || i == 3 || i == 5 || i == 7) ? 8'h01 : 8'h00;
            s1[i].en       = 1'b1;
            s1[i].lreq     = 1'b0;
            s1[i].exp_done = (i == 9);
        end
        for (int i = 0; i < 8; i++) begin
            rt[i].addr = 4'(i);
            rt[i].exp  = (i == 0) ? 4 : 0;
        end
        rt[8].addr = 4'd9;
        rt[8].exp  = 0;

        rst = 1; flag = 0; en = 1; lreq = 0; rden = 0; addr = 0;
        b_rst = 1; b_flag = 0; b_en = 1; b_lreq = 0; b_rden = 0; b_addr = 0;

        // Saturation on a 4-bit counter
        step_b();
        chk("b_reset_gcnt", b_gcnt, 0);
        chk("b_reset_rd", b_rdd, 0);
        b_rst = 0;
        for (int i = 0; i < 32; i++) begin
            b_flag = (i < 20) ? 8'h80 : 8'h00;
            step_b();
            chk("b_done", b_done, i == 31);
        end
        b_flag = 0; b_rden = 1; b_addr = 3'd7;
        step_b();
        chk("b_sat_ch7", b_rdd, B_SAT);
        chk("b_rdv", b_rdv, 1);
        b_addr = 3'd0;
        step_b();
        chk("b_ch0", b_rdd, 0);
        b_rden = 0;

        // Four ch0 pulses in first gate
        reset_a();
        chk("rst_gcnt", gcnt, 0);
        chk("rst_done", done, 0);
        for (int i = 0; i < 11; i++) begin
            flag = s1[i].flag; en = s1[i].en; lreq = s1[i].lreq;
            step();
            chk("s1_done", done, s1[i].exp_done);
        end
        chk("s1_gcnt", gcnt, 1);
        flag = 0;
        for (int i = 0; i < 9; i++) begin
            rden = 1; addr = rt[i].addr;
            step();
            chk("s1_rd", rdd, rt[i].exp);
            chk("s1_rdv", rdv, 1);
        end
        rden = 0;

        // Continuous ch3: every gate holds exactly GC
        reset_a();
        flag = 8'h08; rden = 1; addr = 4'd3;
        for (int i = 1; i <= 35; i++) begin
            step();
            if (i >= 11) chk("s2_ch3", rdd, GC);
        end
        chk("s2_gcnt", gcnt, 3);
        rden = 0;

        // Early latch at timer 3, repeat in LATCH ignored
        reset_a();
        flag = 8'h02;
        for (int i = 1; i <= 3; i++) step();
        lreq = 1;
        step();
        chk("s4_done", done, 1);
        rden = 1; addr = 4'd1;
        step();
        chk("s4_dbl_done", done, 0);
        chk("s4_gcnt", gcnt, 1);
        chk("s4_ch1", rdd, 4);
        lreq = 0; rden = 0;
        for (int i = 6; i <= 14; i++) begin
            step();
            chk("s4_next_gate", done, i == 14);
        end
        flag = 0; rden = 1; addr = 4'd1;
        step();
        chk("s4_ch1_full", rdd, GC);
        rden = 0;

        // Enable low for a whole gate
        reset_a();
        en = 0; flag = 8'hFF;
        for (int i = 1; i <= GC; i++) begin
            step();
            chk("s5_done", done, i == GC);
        end
        en = 1; flag = 0; rden = 1;
        for (int i = 0; i < 8; i++) begin
            addr = 4'(i);
            step();
            chk("s5_rd", rdd, 0);
        end
        rden = 0;

        // Reset at timer 5 mid-gate
        reset_a();
        flag = 8'hFF;
        for (int i = 1; i <= 15; i++) step();
        chk("s6_pre_gcnt", gcnt, 1);
        rst = 1;
        step();
        rst = 0; flag = 0;
        chk("s6_gcnt", gcnt, 0);
        chk("s6_done", done, 0);
        for (int i = 1; i <= GC; i++) begin
            rden = 1; addr = 4'(i % 8);
            step();
            chk("s6_rd", rdd, 0);
            chk("s6_gate", done, i == GC);
        end
        rden = 0;

        // Randomized run against the model
        reset_a();
        for (int i = 0; i < 800; i++) begin
            flag = 8'($urandom);
            en   = ($urandom_range(0, 7) != 0);
            lreq = ($urandom_range(0, 14) == 0);
            rst  = ($urandom_range(0, 249) == 0);
            rden = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 15));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
